// File: rtl/usb_crc_pkg.sv
// Shared types and USB CRC constants for the serial CRC engine.
package usb_crc_pkg;

   typedef enum logic [1:0] {StIdle, StData, StEmit, StCheck} crc_state_e;

   localparam logic [4:0]  CRC5_POLY     = 5'h05;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
   localparam logic [15:0] CRC16_POLY    = 16'h8005;
   localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/crc_lfsr.sv
// Galois-style CRC shift register: loads all ones, absorbs serial data, or shifts the
// finished CRC out MSB first.
module crc_lfsr #(
   parameter int unsigned         CRC_W = 5,
   parameter logic [CRC_W-1:0]    POLY  = 5'h05
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             shift_in,
   input  logic             shift_out,
   input  logic             din,
   output logic [CRC_W-1:0] r
);

   logic fb;

   assign fb = din ^ r[CRC_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '1;
      end else if (init) begin
         r <= '1;
      end else if (shift_in) begin
         r <= {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end else if (shift_out) begin
         r <= {r[CRC_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/crc_engine.sv
// Serial CRC generator/checker: absorbs len data bits, then either emits the inverted CRC
// with a ready handshake or compares the register against the good-packet residue.
module crc_engine
   import usb_crc_pkg::*;
#(
   parameter int unsigned      CRC_W   = 5,
   parameter logic [CRC_W-1:0] POLY    = CRC5_POLY,
   parameter logic [CRC_W-1:0] RESIDUE = CRC5_RESIDUE,
   parameter int unsigned      LEN_W   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             s_in,
   input  logic             s_valid,
   input  logic             out_ready,
   output logic             crc_out,
   output logic             crc_out_valid,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err
);

   localparam logic [LEN_W-1:0] EmitLast = LEN_W'(CRC_W - 1);

   crc_state_e       state;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_inc;
   logic [LEN_W-1:0] len_q;
   logic             mode_q;
   logic             ok_q;
   logic             err_q;
   logic [CRC_W-1:0] r;
   logic             init;
   logic             shift_in;
   logic             shift_out;
   logic             match;
   logic             emit_last;

   assign cnt_inc   = cnt + 1'b1;
   assign match     = (r == RESIDUE);
   assign emit_last = (cnt == EmitLast);

   // Abort wins over every register update, including the CRC register itself.
   assign init      = !abort && (state == StIdle) && start;
   assign shift_in  = !abort && (state == StData) && s_valid;
   assign shift_out = !abort && (state == StEmit) && out_ready;

   crc_lfsr #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (init),
      .shift_in  (shift_in),
      .shift_out (shift_out),
      .din       (s_in),
      .r         (r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= StIdle;
         cnt    <= '0;
         len_q  <= '0;
         mode_q <= 1'b0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
      end else if (abort) begin
         state <= StIdle;
         cnt   <= '0;
         ok_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  cnt    <= '0;
                  len_q  <= len;
                  mode_q <= mode;
                  ok_q   <= 1'b0;
                  err_q  <= 1'b0;
                  if (len != '0) state <= StData;
                  else           state <= mode ? StCheck : StEmit;
               end
            end
            StData: begin
               if (s_valid) begin
                  cnt <= cnt_inc;
                  // Counter is reused for the emit handshakes, so rewind it on exit.
                  if (cnt_inc == len_q) begin
                     cnt   <= '0;
                     state <= mode_q ? StCheck : StEmit;
                  end
               end
            end
            StEmit: begin
               if (out_ready) begin
                  cnt <= cnt_inc;
                  if (emit_last) begin
                     cnt   <= '0;
                     state <= StIdle;
                  end
               end
            end
            StCheck: begin
               ok_q  <= match;
               err_q <= !match;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      crc_out_valid = (state == StEmit);
      crc_out       = (state == StEmit) ? !r[CRC_W-1] : 1'b0;
      busy          = (state != StIdle);
      done          = !abort && ((state == StCheck) ||
                                 ((state == StEmit) && out_ready && emit_last));
      crc_ok        = (state == StCheck) ? match  : ok_q;
      crc_err       = (state == StCheck) ? !match : err_q;
   end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine at CRC_W=5 and CRC_W=16, against a polynomial
// long-division reference model.
module tb_crc_engine;
   import usb_crc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel16 = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [10:0] len = '0;
   logic        abort = 1'b0;
   logic        s_in = 1'b0;
   logic        s_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic co5, cov5, busy5, done5, ok5, err5;
   logic co16, cov16, busy16, done16, ok16, err16;
   logic crc_out, crc_out_valid, busy, done, crc_ok, crc_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   crc_engine #(
      .CRC_W(5), .POLY(CRC5_POLY), .RESIDUE(CRC5_RESIDUE), .LEN_W(11)
   ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel16), .mode(mode), .len(len),
      .abort(abort & ~sel16), .s_in(s_in), .s_valid(s_valid & ~sel16),
      .out_ready(out_ready & ~sel16), .crc_out(co5), .crc_out_valid(cov5), .busy(busy5),
      .done(done5), .crc_ok(ok5), .crc_err(err5)
   );

   crc_engine #(
      .CRC_W(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE), .LEN_W(11)
   ) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start & sel16), .mode(mode), .len(len),
      .abort(abort & sel16), .s_in(s_in), .s_valid(s_valid & sel16),
      .out_ready(out_ready & sel16), .crc_out(co16), .crc_out_valid(cov16), .busy(busy16),
      .done(done16), .crc_ok(ok16), .crc_err(err16)
   );

   assign crc_out       = sel16 ? co16   : co5;
   assign crc_out_valid = sel16 ? cov16  : cov5;
   assign busy          = sel16 ? busy16 : busy5;
   assign done          = sel16 ? done16 : done5;
   assign crc_ok        = sel16 ? ok16   : ok5;
   assign crc_err       = sel16 ? err16  : err5;

   function automatic int cw();
      return sel16 ? 16 : 5;
   endfunction

   // Remainder of (ones * x^n + M * x^w) mod G, i.e. the register after an all-ones init.
   function automatic logic [15:0] model_rem(input bit msg[$]);
      bit          b[$];
      int          n;
      int          w;
      logic [15:0] poly;
      logic [15:0] rem;
      w    = cw();
      poly = sel16 ? CRC16_POLY : {11'd0, CRC5_POLY};
      b    = msg;
      n    = msg.size();
      for (int i = 0; i < w; i++) b.push_back(1'b0);
      for (int i = 0; i < w; i++) b[i] = ~b[i];
      for (int i = 0; i < n; i++)
         if (b[i]) for (int j = 1; j <= w; j++) b[i+j] ^= poly[w-j];
      rem = '0;
      for (int j = 0; j < w; j++) rem[w-1-j] = b[n+j];
      return rem;
   endfunction

   function automatic logic [15:0] model_gen(input bit msg[$]);
      logic [15:0] mask;
      mask = sel16 ? 16'hFFFF : 16'h001F;
      return ~model_rem(msg) & mask;
   endfunction

   function automatic bit model_ok(input bit msg[$]);
      logic [15:0] res;
      res = sel16 ? CRC16_RESIDUE : {11'd0, CRC5_RESIDUE};
      return model_rem(msg) == res;
   endfunction

   task automatic do_start(input bit m, input int l);
      start = 1'b1;
      mode  = m;
      len   = l[10:0];
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input bit msg[$], input bit gaps);
      foreach (msg[i]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_valid = 1'b0;
               s_in    = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         s_valid = 1'b1;
         s_in    = msg[i];
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   // rmode: 0 random ready, 1 toggling starting at 1, 2 always ready.
   task automatic collect(input int rmode, input string name, output logic [15:0] got);
      int n = 0;
      int cyc = 0;
      bit tog = 1'b1;
      int w = cw();
      got = '0;
      while (n < w && cyc < 300) begin
         out_ready = (rmode == 0) ? 1'($urandom) : (rmode == 1) ? tog : 1'b1;
         tog = ~tog;
         @(negedge clk);
         checks++;
         if (crc_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b want 1 (bit %0d)", name, crc_out_valid, n);
         end
         if (out_ready) begin
            got[w-1-n] = crc_out;
            n++;
         end
         checks++;
         if (done !== (out_ready && n == w)) begin
            errors++;
            $display("FAIL %s done: got %b want %b (bit %0d)", name, done,
                     out_ready && n == w, n);
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (n != w) begin
         errors++;
         $display("FAIL %s emit timeout: got %0d bits want %0d", name, n, w);
      end
   endtask

   task automatic run_gen(input bit msg[$], input bit gaps, input int rmode,
                          input string name, output logic [15:0] got);
      logic [15:0] exp;
      exp = model_gen(msg);
      do_start(1'b0, msg.size());
      feed(msg, gaps);
      collect(rmode, name, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s crc: got %h want %h", name, got, exp);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s idle after emit: busy %b done %b want 0 0", name, busy, done);
      end
   endtask

   task automatic run_check(input bit msg[$], input bit gaps, input bit exp_ok,
                            input string name);
      do_start(1'b1, msg.size());
      feed(msg, gaps);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || crc_ok !== exp_ok || crc_err !== !exp_ok) begin
         errors++;
         $display("FAIL %s check: done %b ok %b err %b want 1 %b %b", name, done, crc_ok,
                  crc_err, exp_ok, !exp_ok);
      end
      @(posedge clk); #1;
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || crc_ok !== exp_ok || crc_err !== !exp_ok) begin
         errors++;
         $display("FAIL %s hold: done %b busy %b ok %b err %b want 0 0 %b %b", name, done,
                  busy, crc_ok, crc_err, exp_ok, !exp_ok);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel16 = 1'(s);
         #1;
         checks++;
         if ({crc_out, crc_out_valid, busy, done, crc_ok, crc_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset outputs w%0d: got %b want 000000", cw(),
                     {crc_out, crc_out_valid, busy, done, crc_ok, crc_err});
         end
      end
      sel16 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gen5_zeros();
      bit          msg[$];
      logic [15:0] got;
      sel16 = 1'b0;
      msg = {};
      repeat (11) msg.push_back(1'b0);
      run_gen(msg, 1'b0, 2, "gen5_zeros", got);
      checks++;
      if (got !== 16'h0008) begin
         errors++;
         $display("FAIL gen5_zeros const: got %h want 0008", got);
      end
   endtask

   task automatic test_check5();
      bit msg[$];
      bit bad[$];
      sel16 = 1'b0;
      msg = {};
      repeat (11) msg.push_back(1'b0);
      msg.push_back(1'b0); msg.push_back(1'b1); msg.push_back(1'b0);
      msg.push_back(1'b0); msg.push_back(1'b0);
      run_check(msg, 1'b1, 1'b1, "check5_good");
      for (int k = 0; k < 4; k++) begin
         bad = msg;
         bad[$urandom_range(0, 15)] ^= 1'b1;
         run_check(bad, 1'b1, 1'b0, "check5_flip");
      end
   endtask

   task automatic test_random16();
      bit          msg[$];
      bit          pkt[$];
      logic [15:0] got;
      sel16 = 1'b1;
      for (int p = 0; p < 100; p++) begin
         msg = {};
         repeat (8 * $urandom_range(1, 4)) msg.push_back(1'($urandom));
         run_gen(msg, 1'b1, 0, "gen16", got);
         pkt = msg;
         for (int j = 15; j >= 0; j--) pkt.push_back(got[j]);
         run_check(pkt, 1'b1, model_ok(pkt), "loop16");
         checks++;
         if (crc_ok !== 1'b1) begin
            errors++;
            $display("FAIL loop16 ok: got %b want 1 (packet %0d)", crc_ok, p);
         end
      end
      sel16 = 1'b0;
   endtask

   task automatic test_len0();
      bit          msg[$];
      logic [15:0] got;
      sel16 = 1'b0;
      msg = {};
      run_gen(msg, 1'b0, 1, "len0", got);
      checks++;
      if (got !== 16'h0000) begin
         errors++;
         $display("FAIL len0 const: got %h want 0000", got);
      end
   endtask

   task automatic test_max_len();
      bit          msg[$];
      logic [15:0] got;
      sel16 = 1'b0;
      msg = {};
      repeat (2047) msg.push_back(1'($urandom));
      run_gen(msg, 1'b0, 0, "max_len", got);
   endtask

   task automatic test_abort_reset();
      bit          msg[$];
      bit          seen;
      logic [15:0] got;
      sel16 = 1'b0;
      msg = {};
      repeat (16) msg.push_back(1'b0);
      msg[12] = 1'b1;
      run_check(msg, 1'b0, 1'b1, "pre_abort");
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (crc_ok !== 1'b0 || crc_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle results: ok %b err %b want 0 0", crc_ok, crc_err);
      end
      do_start(1'b0, 11);
      repeat (4) begin
         s_valid = 1'b1; s_in = 1'($urandom);
         @(posedge clk); #1;
      end
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_data done: got %b want 0", done);
      end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || crc_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_data idle: busy %b valid %b want 0 0", busy, crc_out_valid);
      end
      @(posedge clk); #1;
      do_start(1'b0, 11);
      repeat (11) begin
         s_valid = 1'b1; s_in = 1'($urandom);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      rst_n = 1'b0;
      seen = 1'b0;
      #2;
      checks++;
      if ({crc_out, crc_out_valid, busy, done, crc_ok, crc_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_emit outputs: got %b want 000000",
                  {crc_out, crc_out_valid, busy, done, crc_ok, crc_err});
      end
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         seen |= done;
      end
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         seen |= done | busy;
      end
      out_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_emit quiet: done/busy seen %b want 0", seen);
      end
      @(posedge clk); #1;
      msg = {};
      repeat (11) msg.push_back(1'($urandom));
      run_gen(msg, 1'b1, 0, "post_reset", got);
   endtask

   task automatic test_busy_ignore();
      bit          msg[$];
      logic [15:0] exp;
      logic [15:0] got;
      sel16 = 1'b0;
      msg = {};
      repeat (8) msg.push_back(1'($urandom));
      exp = model_gen(msg);
      do_start(1'b0, 8);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            start = 1'b1; mode = 1'b1; len = 11'd3; s_valid = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
         end
         s_valid = 1'b1; s_in = msg[i];
         @(posedge clk); #1;
      end
      start = 1'b1;
      s_valid = 1'b1;
      s_in = 1'b1;
      collect(0, "busy_ignore", got);
      start = 1'b0;
      s_valid = 1'b0;
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL busy_ignore crc: got %h want %h", got, exp);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || crc_ok !== 1'b0 || crc_err !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore idle: busy %b ok %b err %b want 0 0 0", busy, crc_ok,
                  crc_err);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_gen5_zeros();
      test_check5();
      test_len0();
      test_busy_ignore();
      test_abort_reset();
      test_max_len();
      test_random16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
